// File: rtl/norm_float_to_fixed_mc_if.sv
// Request/result bundle of the multi-channel float-to-fixed normaliser.
// Channel i occupies lane i of every vector.
interface norm_float_to_fixed_mc_if #(
    parameter int CH = 2,
    parameter int P  = 32,
    parameter int FW = 32
);
    logic [CH-1:0]    Begin_FSM;
    logic [CH*P-1:0]  F;
    logic [CH*8-1:0]  GAIN;
    logic [CH-1:0]    ACK;
    logic [CH*FW-1:0] RESULT;
    logic [CH-1:0]    OVF;
    logic             BUSY;

    modport master (
        output Begin_FSM, F, GAIN,
        input  ACK, RESULT, OVF, BUSY
    );

    modport slave (
        input  Begin_FSM, F, GAIN,
        output ACK, RESULT, OVF, BUSY
    );
endinterface

// File: rtl/norm_float_to_fixed_mc.sv
// Multi-channel float to fixed normaliser: per-channel request latches,
// round-robin grant, one shared unpack/align/sign datapath.
module norm_float_to_fixed_mc #(
    parameter int P    = 32,
    parameter int EW   = 8,
    parameter int SW   = 23,
    parameter int FW   = 32,
    parameter int FRAC = 26,
    parameter int CH   = 2
) (
    input logic                     CLK,
    input logic                     RST_FF,
    norm_float_to_fixed_mc_if.slave bus
);
    localparam int CW   = (CH > 1) ? $clog2(CH) : 1;
    localparam int SHW  = 12;
    localparam int BIAS = (1 << (EW - 1)) - 1;

    localparam logic signed [SHW-1:0] SH_OFS = SHW'(FRAC - SW - BIAS);
    localparam logic signed [SHW-1:0] SH_MAX = SHW'(FW - 2 - SW);
    localparam logic [SHW-1:0]        SH_LIM = SHW'(SW);
    localparam logic [FW-1:0]         POS_SAT = {1'b0, {(FW-1){1'b1}}};
    localparam logic [FW-1:0]         NEG_SAT = {1'b1, {(FW-1){1'b0}}};
    localparam logic [CW-1:0]         LAST_CH = CW'(CH - 1);

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        ALIGN,
        SIGN,
        DONE
    } state_t;

    state_t state;

    logic [CH-1:0]    pending;
    logic [P-1:0]     f_q    [CH];
    logic [7:0]       gain_q [CH];

    logic [CW-1:0]    ptr;
    logic [CW-1:0]    cur;
    logic [CW-1:0]    gsel;
    logic [CW-1:0]    cand;
    logic             any;

    logic [P-1:0]     op_f;
    logic [7:0]       op_gain;

    logic             s_q;
    logic             zero_q;
    logic             spec_q;
    logic [SW:0]      mant_q;
    logic signed [SHW-1:0] sh_q;

    logic [FW-1:0]    mag_q;
    logic             ovf_q;

    logic [CH-1:0]    ack_q;
    logic [CH-1:0]    ovf_out;
    logic [CH*FW-1:0] result_q;

    logic [EW-1:0]    e_w;
    logic signed [SHW-1:0] sh_d;
    logic [SHW-1:0]   sh_abs;
    logic [FW-1:0]    mant_fw;
    logic [FW-1:0]    mag_d;
    logic             ovf_d;
    logic [FW-1:0]    res_d;

    // Round-robin search starting at the pointer.
    always_comb begin
        any  = 1'b0;
        gsel = '0;
        cand = '0;
        for (int k = 0; k < CH; k++) begin
            cand = CW'((int'(ptr) + k) % CH);
            if (!any && pending[cand]) begin
                any  = 1'b1;
                gsel = cand;
            end
        end
    end

    assign e_w  = op_f[P-2 -: EW];
    assign sh_d = $signed({{(SHW-EW){1'b0}}, e_w})
                + $signed({{(SHW-8){op_gain[7]}}, op_gain})
                + SH_OFS;

    // Any left shift beyond SH_MAX pushes the leading one into the sign bit.
    always_comb begin
        mant_fw = {{(FW-SW-1){1'b0}}, mant_q};
        sh_abs  = sh_q[SHW-1] ? -sh_q : sh_q;
        mag_d   = '0;
        ovf_d   = 1'b0;
        if (!zero_q) begin
            if (spec_q || (sh_q > SH_MAX)) begin
                ovf_d = 1'b1;
            end else if (!sh_q[SHW-1]) begin
                mag_d = mant_fw << sh_abs;
            end else if (sh_abs <= SH_LIM) begin
                mag_d = mant_fw >> sh_abs;
            end
        end
    end

    always_comb begin
        res_d = s_q ? -mag_q : mag_q;
        if (ovf_q) begin
            res_d = s_q ? NEG_SAT : POS_SAT;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST_FF) begin
            state    <= IDLE;
            pending  <= '0;
            ptr      <= '0;
            cur      <= '0;
            op_f     <= '0;
            op_gain  <= '0;
            s_q      <= 1'b0;
            zero_q   <= 1'b0;
            spec_q   <= 1'b0;
            mant_q   <= '0;
            sh_q     <= '0;
            mag_q    <= '0;
            ovf_q    <= 1'b0;
            ack_q    <= '0;
            ovf_out  <= '0;
            result_q <= '0;
            for (int i = 0; i < CH; i++) begin
                f_q[i]    <= '0;
                gain_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (bus.Begin_FSM[i] && !pending[i]) begin
                    pending[i] <= 1'b1;
                    f_q[i]     <= bus.F[i*P +: P];
                    gain_q[i]  <= bus.GAIN[i*8 +: 8];
                end
            end
            ack_q <= '0;
            unique case (state)
                IDLE: begin
                    if (any) begin
                        cur           <= gsel;
                        op_f          <= f_q[gsel];
                        op_gain       <= gain_q[gsel];
                        pending[gsel] <= 1'b0;
                        ptr           <= (gsel == LAST_CH) ? '0 : gsel + 1'b1;
                        state         <= UNPACK;
                    end
                end
                UNPACK: begin
                    s_q    <= op_f[P-1];
                    zero_q <= (e_w == '0);
                    spec_q <= (e_w == '1);
                    mant_q <= {1'b1, op_f[SW-1:0]};
                    sh_q   <= sh_d;
                    state  <= ALIGN;
                end
                ALIGN: begin
                    mag_q <= mag_d;
                    ovf_q <= ovf_d;
                    state <= SIGN;
                end
                SIGN: begin
                    result_q[cur*FW +: FW] <= res_d;
                    ovf_out[cur]           <= ovf_q;
                    ack_q[cur]             <= 1'b1;
                    state                  <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ACK    = ack_q;
    assign bus.RESULT = result_q;
    assign bus.OVF    = ovf_out;
    assign bus.BUSY   = (|pending) || (state != IDLE);
endmodule

// File: doc/norm_float_to_fixed_mc.md
# norm_float_to_fixed_mc

Multi-channel floating-point to fixed-point normaliser, the parametrised successor of the single-channel current/voltage float-to-fixed stage behind the CORDIC logarithm linearizer. CH independent request channels, each with its own Begin_FSM/ACK handshake and per-channel exponent gain, share one multi-cycle conversion datapath under round-robin arbitration. Sits between the CORDIC float results (or raw float samples) and the fixed-point control/filter logic; replaces the separate per-channel converters, so both the I and V paths are served by one block.

## Interface
- P, 32: float width; P = 1 + EW + SW.
- EW, 8: exponent width; bias = 2^(EW-1)-1.
- SW, 23: stored mantissa width.
- FW, 32: fixed-point output width, two's complement.
- FRAC, 26: fractional bits in the output.
- CH, 2: number of channels (1..8).

- CLK  in  1  system clock.
- RST_FF  in  1  reset; one clock; reset is synchronous and active-high.
- Begin_FSM  in  CH  per-channel request pulse; F sampled same cycle.
- F  in  CH*P  per-channel float operand, channel i at [i*P +: P].
- GAIN  in  CH*8  per-channel signed exponent offset (value × 2^GAIN), sampled with Begin_FSM.
- ACK  out  CH  per-channel one-cycle done pulse.
- RESULT  out  CH*FW  per-channel fixed result, channel i at [i*FW +: FW]; held until next ACK of that channel.
- OVF  out  CH  per-channel saturation flag, updated with ACK, held.
- BUSY  out  1  high when any request pending or conversion in progress.

## Operation
- Per channel: pending flag plus latched F and GAIN. Begin_FSM[i] with pending[i]=0 sets pending[i] and latches operands. Begin_FSM[i] with pending[i]=1 is ignored (first operands kept). Begin_FSM[i] while channel i is being converted (pending already cleared) is accepted and queued.
- Arbiter: round-robin, pointer = 0 after reset; on grant of channel g, pointer = (g+1) mod CH. Grant only in IDLE.
- FSM: IDLE → (any pending) grant, copy operands to datapath, clear pending[g] → UNPACK → ALIGN → SIGN → DONE → IDLE. IDLE with nothing pending stays IDLE.
- UNPACK: s, e, m; sh = e − bias + GAIN + FRAC − SW, computed in ≥12-bit signed.
- ALIGN: magnitude = {1,m} << sh for sh ≥ 0, >> −sh for sh < 0 (truncation toward zero); sh ≤ −(SW+1) gives 0. Overflow when magnitude ≥ 2^(FW−1) (evaluate in an extended-width shifter or via sh > FW−2−SW).
- SIGN: negate if s=1. Overflow: RESULT = 2^(FW−1)−1 if s=0, −2^(FW−1) if s=1, OVF=1.
- Special: e=0 (zero/denormal) → 0, OVF=0. e all-ones (Inf/NaN) → saturate by sign, OVF=1.
- DONE: write RESULT[g], OVF[g], pulse ACK[g].
- RST_FF: FSM IDLE, all pending cleared, pointer 0, ACK=0, RESULT=0, OVF=0, BUSY=0; Begin_FSM in a reset cycle ignored; conversion in flight discarded, no ACK.

## Timing
- Idle block, Begin_FSM[i] high in cycle 0 → pending cycle 1 (IDLE grant) → UNPACK 2, ALIGN 3, SIGN 4, DONE 5: ACK[i] high in cycle 5 exactly, one cycle; RESULT valid from cycle 5.
- Next grant earliest in cycle 6 (IDLE); throughput one conversion per 5 cycles; a queued channel's ACK follows 5 cycles after the previous ACK.
- Begin_FSM[i] in the same cycle as ACK[i] is accepted; its ACK is ≥5 cycles later.
- BUSY high from cycle after Begin sample until the IDLE cycle with no pending.

## Test plan
- CH=2, FRAC=16, GAIN=0: ch0 F=0x3FC00000 (1.5) at cycle 0 → ACK[0] cycle 5, RESULT0=0x00018000, OVF0=0; F=0xC0200000 (−2.5) → 0xFFFD8000.
- Overflow/specials, FRAC=16: 0x47000000 (32768) → 0x7FFFFFFF, OVF=1; 0xC7000000 → 0x80000000, OVF=1; 0x7F800000 → 0x7FFFFFFF, OVF=1; 0x00000000 → 0, OVF=0; 0x33800000 (2^−24) → 0, OVF=0.
- Gain: ch1 GAIN=−3 (0xFD), F=0x41000000 (8.0) → RESULT1=0x00010000.
- Arbitration: Begin_FSM=2'b11 cycle 0 → ACK[0] cycle 5, ACK[1] cycle 10; ch0 reissued every ACK[0] while ch1 reissued every ACK[1] → ACKs strictly alternate, no starvation; duplicate Begin on pending channel keeps first F.
- Reset mid-op: Begin ch0 cycle 0, RST_FF high cycle 3 → no ACK ever, RESULT=0, BUSY=0 cycle 4; new Begin cycle 5 → ACK cycle 10.
